// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and arbiter state encoding
package uart_pkg;

  localparam int UART_FRAME_BITS      = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 217;  // 25 MHz / 115200

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_GRANTED = 2'd1;
  localparam arb_state_t ST_TX      = 2'd2;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serializer; load starts the frame on the same edge
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(UART_FRAME_BITS - 1);

  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          active;

  assign done = active && (bit_cnt == BIT_END) && (bit_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      active  <= 1'b0;
    end else if (load) begin
      tx      <= 1'b0;
      shreg   <= data;
      bit_cnt <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (bit_cnt == BIT_END) begin
        bit_cnt <= '0;
        if (bit_idx == LAST_IDX) begin
          active  <= 1'b0;
          bit_idx <= '0;
          tx      <= 1'b1;
        end else begin
          // after data[7] comes the stop bit; otherwise shift out LSB-first
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == LAST_IDX - 4'd1) ? 1'b1 : shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
        end
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular sharing of one UART TX line
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int   NUM_REQ       = 4,
  parameter int   CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter int   STALL_TIMEOUT = 4096,
  localparam int  GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_out,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam int            SW        = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_END = SW'(STALL_TIMEOUT - 1);

  arb_state_t    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] scan_idx;
  logic          found;
  logic [SW-1:0] stall_cnt;
  logic          last_q;
  logic [7:0]    grant_data;
  logic          accept;
  logic          tx_done;

  // Scan upward from the requester after the previous grantee, wrapping.
  always_comb begin
    next_grant = last_grant;
    scan_idx   = last_grant;
    found      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (scan_idx == GW'(NUM_REQ - 1)) ? '0 : scan_idx + GW'(1);
      if (!found && req_valid[scan_idx]) begin
        found      = 1'b1;
        next_grant = scan_idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) grant_data = req_data[8*i +: 8];
    end
  end

  assign accept    = (state == ST_GRANTED) && req_valid[grant_id];
  assign req_ready = (state == ST_GRANTED) ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      stall_cnt  <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_id   <= next_grant;
            last_grant <= next_grant;
            stall_cnt  <= '0;
            state      <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (accept) begin
            last_q    <= req_last[grant_id];
            stall_cnt <= '0;
            state     <= ST_TX;
          end else if (stall_cnt == STALL_END) begin
            stall_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        ST_TX: begin
          if (tx_done) state <= last_q ? ST_IDLE : ST_GRANTED;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .data (grant_data),
    .tx   (uart_out),
    .done (tx_done)
  );

endmodule
